// File: rtl/vga_timing_pkg.sv
// Shared VGA timing definitions.
// Holds the 640x480@60 timing constants used as defaults by vga_timing_gen,
// the per-pixel flag bundle carried through the display pipeline, and a
// helper that checks a line/frame total fits in an address width.
package vga_timing_pkg;

  localparam int unsigned VGA_H_SYNC   = 96;
  localparam int unsigned VGA_H_BACK   = 48;
  localparam int unsigned VGA_H_ACTIVE = 640;
  localparam int unsigned VGA_H_FRONT  = 16;
  localparam int unsigned VGA_V_SYNC   = 2;
  localparam int unsigned VGA_V_BACK   = 33;
  localparam int unsigned VGA_V_ACTIVE = 480;
  localparam int unsigned VGA_V_FRONT  = 10;

  // Sync flags are carried as "active" (1 = in sync pulse) so that a cleared
  // pipeline stage always means inactive, whatever the output polarity.
  typedef struct packed {
    logic hs_act;
    logic vs_act;
    logic ready;
    logic line_start;
    logic frame_start;
  } vga_flags_t;

  // True when a counter running 0..total-1 fits in 'width' bits.
  function automatic bit total_fits(input int unsigned total,
                                    input int unsigned width);
    if (width >= 32) return 1'b1;
    return total <= (32'd1 << width);
  endfunction

endpackage

// File: rtl/vga_delay_line.sv
// Fixed-latency shift pipeline.
// Ports: CLK, RST_n (async active-low clear of every stage), din (WIDTH bits),
// dout = din delayed DEPTH clocks. DEPTH = 0 is a plain wire.
module vga_delay_line #(
  parameter int unsigned WIDTH = 1,
  parameter int unsigned DEPTH = 1
) (
  input  logic             CLK,
  input  logic             RST_n,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  if (DEPTH == 0) begin : g_wire
    logic unused_clk_rst;
    assign unused_clk_rst = &{1'b0, CLK, RST_n};
    assign dout = din;
  end else begin : g_pipe
    logic [WIDTH-1:0] stage [DEPTH];

    always_ff @(posedge CLK or negedge RST_n) begin
      if (!RST_n) begin
        for (int unsigned i = 0; i < DEPTH; i++) stage[i] <= '0;
      end else begin
        stage[0] <= din;
        for (int unsigned i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
      end
    end

    assign dout = stage[DEPTH-1];
  end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator.
// Ports: CLK pixel clock, RST_n async active-low reset, Enable_Sig run enable.
// Fetch stage (registered from the h/v counters): Fetch_Sig, Fetch_Col_Sig,
// Fetch_Row_Sig. Display stage (fetch stage delayed PREFETCH clocks):
// HSYNC_Sig, VSYNC_Sig, Ready_Sig, Column_Addr_Sig, Row_Addr_Sig,
// Line_Start_Sig, Frame_Start_Sig.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int unsigned H_SYNC   = VGA_H_SYNC,
  parameter int unsigned H_BACK   = VGA_H_BACK,
  parameter int unsigned H_ACTIVE = VGA_H_ACTIVE,
  parameter int unsigned H_FRONT  = VGA_H_FRONT,
  parameter int unsigned V_SYNC   = VGA_V_SYNC,
  parameter int unsigned V_BACK   = VGA_V_BACK,
  parameter int unsigned V_ACTIVE = VGA_V_ACTIVE,
  parameter int unsigned V_FRONT  = VGA_V_FRONT,
  parameter bit          HS_POL   = 1'b0,
  parameter bit          VS_POL   = 1'b0,
  parameter int unsigned PREFETCH = 2,
  parameter int unsigned ADDR_W   = 11
) (
  input  logic              CLK,
  input  logic              RST_n,
  input  logic              Enable_Sig,
  output logic              Fetch_Sig,
  output logic [ADDR_W-1:0] Fetch_Col_Sig,
  output logic [ADDR_W-1:0] Fetch_Row_Sig,
  output logic              HSYNC_Sig,
  output logic              VSYNC_Sig,
  output logic              Ready_Sig,
  output logic [ADDR_W-1:0] Column_Addr_Sig,
  output logic [ADDR_W-1:0] Row_Addr_Sig,
  output logic              Line_Start_Sig,
  output logic              Frame_Start_Sig
);

  localparam int unsigned H_TOTAL = H_SYNC + H_BACK + H_ACTIVE + H_FRONT;
  localparam int unsigned V_TOTAL = V_SYNC + V_BACK + V_ACTIVE + V_FRONT;
  localparam int unsigned HA0     = H_SYNC + H_BACK;
  localparam int unsigned VA0     = V_SYNC + V_BACK;
  localparam int unsigned PIPE_W  = $bits(vga_flags_t) + 2 * ADDR_W;

  localparam logic [ADDR_W-1:0] H_LAST = ADDR_W'(H_TOTAL - 1);
  localparam logic [ADDR_W-1:0] V_LAST = ADDR_W'(V_TOTAL - 1);
  localparam logic [ADDR_W-1:0] HA0_A  = ADDR_W'(HA0);
  localparam logic [ADDR_W-1:0] VA0_A  = ADDR_W'(VA0);

  if (!total_fits(H_TOTAL, ADDR_W) || !total_fits(V_TOTAL, ADDR_W)) begin : g_bad_width
    $error("vga_timing_gen: H_TOTAL/V_TOTAL exceed 2**ADDR_W");
  end
  if (PREFETCH > 7) begin : g_bad_prefetch
    $error("vga_timing_gen: PREFETCH must be 0..7");
  end

  logic [ADDR_W-1:0] h_cnt, v_cnt;
  int unsigned       h_u, v_u;

  // Disabled counters sit at (0,0), so the first enabled edge registers
  // the (0,0) fetch values and the first frame is full-length.
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (!Enable_Sig) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_cnt == H_LAST) begin
      h_cnt <= '0;
      v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
    end else begin
      h_cnt <= h_cnt + 1'b1;
    end
  end

  // Window compares are done at 32 bits so HA0+H_ACTIVE may equal 2**ADDR_W.
  assign h_u = 32'(h_cnt);
  assign v_u = 32'(v_cnt);

  vga_flags_t        flags_d, flags_q;
  logic [ADDR_W-1:0] fcol_d, frow_d, fcol_q, frow_q;

  always_comb begin
    flags_d = '0;
    fcol_d  = '0;
    frow_d  = '0;
    if (Enable_Sig) begin
      flags_d.hs_act = (h_u < H_SYNC);
      flags_d.vs_act = (v_u < V_SYNC);
      if (h_u >= HA0 && h_u < HA0 + H_ACTIVE &&
          v_u >= VA0 && v_u < VA0 + V_ACTIVE) begin
        flags_d.ready       = 1'b1;
        flags_d.line_start  = (h_u == HA0);
        flags_d.frame_start = (h_u == HA0) && (v_u == VA0);
        fcol_d              = h_cnt - HA0_A;
        frow_d              = v_cnt - VA0_A;
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      flags_q <= '0;
      fcol_q  <= '0;
      frow_q  <= '0;
    end else begin
      flags_q <= flags_d;
      fcol_q  <= fcol_d;
      frow_q  <= frow_d;
    end
  end

  assign Fetch_Sig     = flags_q.ready;
  assign Fetch_Col_Sig = fcol_q;
  assign Fetch_Row_Sig = frow_q;

  vga_flags_t        disp_flags;
  logic [ADDR_W-1:0] disp_col, disp_row;

  vga_delay_line #(
    .WIDTH (PIPE_W),
    .DEPTH (PREFETCH)
  ) u_disp_pipe (
    .CLK   (CLK),
    .RST_n (RST_n),
    .din   ({flags_q, fcol_q, frow_q}),
    .dout  ({disp_flags, disp_col, disp_row})
  );

  assign HSYNC_Sig       = disp_flags.hs_act ? HS_POL : !HS_POL;
  assign VSYNC_Sig       = disp_flags.vs_act ? VS_POL : !VS_POL;
  assign Ready_Sig       = disp_flags.ready;
  assign Column_Addr_Sig = disp_col;
  assign Row_Addr_Sig    = disp_row;
  assign Line_Start_Sig  = disp_flags.line_start;
  assign Frame_Start_Sig = disp_flags.frame_start;

endmodule
